// File: rtl/sparc_exu_thr_sched_if.sv
// ---------------------------------------------------------------------------
// sparc_exu_thr_sched_if
// Bundle between the EXU pipeline control (master) and the four-thread issue
// scheduler (slave).
//   thr_rdy    : per-thread instruction-ready request          (master -> slave)
//   wr_req_s   : S-stage instruction writes a per-thread reg   (master -> slave)
//   ll_e       : instruction in E is long-latency              (master -> slave)
//   kill_e     : kill the instruction in E                     (master -> slave)
//   ll_done    : per-thread long-latency completion pulse      (master -> slave)
//   stall      : global pipe hold                              (master -> slave)
//   thr_s      : one-hot S-stage read select, 0 = no issue     (slave -> master)
//   thr_e/m/w  : one-hot thread id in E/M/W, 0 = bubble        (slave -> master)
//   wen_w      : write-back enable                             (slave -> master)
//   thr_parked : per-thread parked status                      (slave -> master)
// ---------------------------------------------------------------------------
interface sparc_exu_thr_sched_if;
    logic [3:0] thr_rdy;
    logic       wr_req_s;
    logic       ll_e;
    logic       kill_e;
    logic [3:0] ll_done;
    logic       stall;
    logic [3:0] thr_s;
    logic [3:0] thr_e;
    logic [3:0] thr_m;
    logic [3:0] thr_w;
    logic       wen_w;
    logic [3:0] thr_parked;

    modport master (
        output thr_rdy, wr_req_s, ll_e, kill_e, ll_done, stall,
        input  thr_s, thr_e, thr_m, thr_w, wen_w, thr_parked
    );

    modport slave (
        input  thr_rdy, wr_req_s, ll_e, kill_e, ll_done, stall,
        output thr_s, thr_e, thr_m, thr_w, wen_w, thr_parked
    );
endinterface

// File: rtl/sparc_exu_thr_sched.sv
// ---------------------------------------------------------------------------
// sparc_exu_thr_sched
// Four-thread round-robin issue scheduler. Picks one eligible thread per cycle
// in S, carries the one-hot thread id and write enable through E/M/W to form
// the write-back select, and parks threads with outstanding long-latency ops
// until their completion pulse returns.
//   clk   : core clock, all state on rising edge
//   reset : synchronous active-high reset
//   se    : scan enable, no functional effect
//   bus   : scheduler side of sparc_exu_thr_sched_if (see interface header)
// ---------------------------------------------------------------------------
module sparc_exu_thr_sched (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        se,
    sparc_exu_thr_sched_if.slave        bus
);

    // Scan enable only matters to the scan-stitched netlist.
    logic se_unused;
    assign se_unused = se;

    logic [3:0] ptr;
    logic [3:0] parked;
    logic [3:0] park_e;
    logic [3:0] elig;
    logic [3:0] grant;
    logic [3:0] thr_s;

    logic [3:0] thr_p0, thr_p1, thr_p2;
    logic       wen_p0, wen_p1, wen_p2;
    logic       vld_p0, vld_p1, vld_p2;

    // First requester at or after the one-hot pointer, wrapping mod 4.
    function automatic logic [3:0] rr_pick(input logic [3:0] req,
                                           input logic [3:0] p);
        logic [3:0] g;
        logic       found;
        logic [1:0] idx;
        g     = '0;
        found = 1'b0;
        idx   = '0;
        for (int s = 0; s < 4; s++) begin
            if (p[s]) begin
                for (int k = 0; k < 4; k++) begin
                    idx = 2'(s + k);
                    if (!found && req[idx]) begin
                        g[idx] = 1'b1;
                        found  = 1'b1;
                    end
                end
            end
        end
        return g;
    endfunction

    // A long-latency op in E parks its thread immediately, so it cannot be
    // re-picked in the same cycle it is discovered.
    assign park_e = thr_p0 & {4{bus.ll_e & ~bus.kill_e & ~bus.stall}};
    assign elig   = bus.thr_rdy & ~parked & ~park_e;
    assign grant  = rr_pick(elig, ptr);
    assign thr_s  = bus.stall ? 4'b0000 : grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 4'b0001;
        end else if (|thr_s) begin
            ptr <= {thr_s[2:0], thr_s[3]};
        end
    end

    // Completion wins over a coincident park; completion is honoured during
    // stall, and a completion for an unparked thread clears nothing.
    always_ff @(posedge clk) begin
        if (reset) begin
            parked <= '0;
        end else begin
            parked <= (parked | park_e) & ~bus.ll_done;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            thr_p0 <= '0;
            wen_p0 <= 1'b0;
            vld_p0 <= 1'b0;
            thr_p1 <= '0;
            wen_p1 <= 1'b0;
            vld_p1 <= 1'b0;
            thr_p2 <= '0;
            wen_p2 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (!bus.stall) begin
            // S -> E
            thr_p0 <= thr_s;
            wen_p0 <= bus.wr_req_s & (|thr_s);
            vld_p0 <= |thr_s;
            // E -> M : kill turns the E entry into a bubble
            thr_p1 <= thr_p0 & ~{4{bus.kill_e}};
            wen_p1 <= wen_p0 & ~bus.kill_e;
            vld_p1 <= vld_p0 & ~bus.kill_e;
            // M -> W
            thr_p2 <= thr_p1;
            wen_p2 <= wen_p1;
            vld_p2 <= vld_p1;
        end
    end

    assign bus.thr_s      = thr_s;
    assign bus.thr_e      = thr_p0;
    assign bus.thr_m      = thr_p1;
    assign bus.thr_w      = thr_p2;
    assign bus.wen_w      = wen_p2 & vld_p2 & (|thr_p2);
    assign bus.thr_parked = parked;

endmodule
